lfsr_step_ctrl: RTL

Sequencing controller wrapped around the 16-bit Galois-style LFSR stage. The LFSR registers a next-state function of its `seed` input every clock and does not feed itself back. This block does that work: it drives the LFSR `seed` input and consumes the LFSR `state` output. On a start request it loads a key, iterates the LFSR a programmed number of steps by feeding `state` back into `seed`, then returns the final word with done/error/wrap status.

---
 rtl/lfsr_step_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/lfsr_step_ctrl.sv
// Sequencing controller for an external 16-bit Galois LFSR stage: loads a key,
// feeds the registered LFSR state back as seed for N steps, and reports the Nth iterate.
module lfsr_step_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W:1]   key,
  input  logic [15:0]  nsteps,
  output logic [W:1]   seed,
  input  logic [W:1]   state,
  output logic         busy,
  output logic         done,
  output logic [W:1]   result,
  output logic         err,
  output logic         wrap
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, FIN} fsm_t;

  fsm_t        fsm;
  logic [W:1]  key_q;
  logic [15:0] n_q;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;

  assign cnt_inc = cnt + 16'd1;

  // The LFSR has no feedback of its own; the seed mux closes the loop during RUN.
  always_comb begin
    seed = '0;
    case (fsm)
      LOAD:    seed = key_q;
      RUN:     seed = state;
      default: seed = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm    <= IDLE;
      key_q  <= '0;
      n_q    <= '0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            key_q <= key;
            n_q   <= nsteps;
            err   <= 1'b0;
            wrap  <= 1'b0;
            if (key == '0) begin
              fsm    <= FIN;
              err    <= 1'b1;
              result <= '0;
              done   <= 1'b1;
            end else if (nsteps == 16'd0) begin
              fsm    <= FIN;
              result <= key;
              done   <= 1'b1;
            end else begin
              fsm  <= LOAD;
              busy <= 1'b1;
            end
          end
        end
        LOAD: begin
          cnt <= 16'd1;
          fsm <= (n_q == 16'd1) ? CAPT : RUN;
        end
        RUN: begin
          // state here is iterate cnt; only iterates before the Nth can flag a wrap
          cnt <= cnt_inc;
          if (state == key_q) wrap <= 1'b1;
          if (cnt_inc == n_q) fsm <= CAPT;
        end
        CAPT: begin
          result <= state;
          busy   <= 1'b0;
          done   <= 1'b1;
          fsm    <= FIN;
        end
        FIN: begin
          fsm <= IDLE;
        end
        default: begin
          fsm  <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
